trig_level_ctrl: RTL and testbench

TRIG_LEVEL_CTRL -- requirements
Module: trig_level_ctrl

---
 rtl/trig_pkg.sv | 33 +++
 rtl/btn_debounce.sv | 46 ++++
 rtl/trig_level_ctrl.sv | 140 ++++++++++++++
 tb/tb_trig_level_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// Shared types and helpers for the trigger-level controller.
// Latency: none (types, constants and combinational helpers only).
// Backpressure: none.
package trig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2,
        ST_LOCK   = 2'd3
    } fsm_state_t;

    localparam logic SLOPE_RISING  = 1'b0;
    localparam logic SLOPE_FALLING = 1'b1;

    localparam int              TRIG_W   = 10;
    localparam logic [TRIG_W:0] TRIG_MAX = 11'd1023;

    // One extra bit of headroom lets both directions clamp instead of wrapping.
    function automatic logic [TRIG_W-1:0] sat_step(input logic [TRIG_W-1:0] lvl,
                                                   input logic [TRIG_W:0]   step,
                                                   input logic              up);
        logic [TRIG_W:0] sum;
        logic [TRIG_W:0] diff;
        sum  = {1'b0, lvl} + step;
        diff = {1'b0, lvl} - step;
        if (up)
            sat_step = (sum > TRIG_MAX) ? TRIG_MAX[TRIG_W-1:0] : sum[TRIG_W-1:0];
        else
            sat_step = diff[TRIG_W] ? '0 : diff[TRIG_W-1:0];
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debouncer for one raw button; emits level and rise pulse.
// Latency: DEBOUNCE_CYC+2 cycles from a stable raw level to the registered level/rise.
// Backpressure: none; the rise pulse is one cycle and is never held.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;

    // The count only runs while the synchronized sample disagrees with the
    // accepted level; any agreeing sample throws the partial count away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            rise    <= 1'b0;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_q2;
                rise  <= sync_q2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/trig_level_ctrl.sv
// Trigger level / slope control from four raw buttons with hold-to-repeat stepping.
// Latency: DEBOUNCE_CYC+3 cycles from a stable press to the registered trig update.
// Backpressure: none; trig_changed is a one-cycle pulse with the new value.
module trig_level_ctrl
    import trig_pkg::*;
#(
    parameter int DEBOUNCE_CYC     = 1000000,
    parameter int REPEAT_DELAY_CYC = 50000000,
    parameter int REPEAT_RATE_CYC  = 10000000,
    parameter int STEP             = 4,
    parameter int LEVEL_INIT       = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_center,
    input  logic              btn_slope,
    output logic [TRIG_W-1:0] trig,
    output logic              trig_slope,
    output logic              trig_changed
);

    localparam int RPT_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC
                                                                   : REPEAT_RATE_CYC;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [RPT_W-1:0]  DELAY_LAST = RPT_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [RPT_W-1:0]  RATE_LAST  = RPT_W'(REPEAT_RATE_CYC - 1);
    localparam logic [TRIG_W-1:0] INIT_VAL   = TRIG_W'(LEVEL_INIT);
    localparam logic [TRIG_W:0]   STEP_VAL   = (TRIG_W + 1)'(STEP);

    logic up_lvl, up_rise;
    logic dn_lvl, dn_rise;
    logic ce_lvl, ce_rise;
    logic sl_lvl, sl_rise;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
        .clk(clk), .rst_n(rst_n), .btn(btn_up),     .level(up_lvl), .rise(up_rise)
    );
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_down (
        .clk(clk), .rst_n(rst_n), .btn(btn_down),   .level(dn_lvl), .rise(dn_rise)
    );
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_center (
        .clk(clk), .rst_n(rst_n), .btn(btn_center), .level(ce_lvl), .rise(ce_rise)
    );
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_slope (
        .clk(clk), .rst_n(rst_n), .btn(btn_slope),  .level(sl_lvl), .rise(sl_rise)
    );

    fsm_state_t        state;
    logic [RPT_W-1:0]  rpt_cnt;
    logic              held_up;

    logic              center_press;
    logic              slope_press;
    logic              held_lvl;
    logic [TRIG_W-1:0] up_val;
    logic [TRIG_W-1:0] dn_val;
    logic [TRIG_W-1:0] first_val;
    logic [TRIG_W-1:0] held_val;

    always_comb begin
        center_press = ce_rise & ce_lvl;
        slope_press  = sl_rise & sl_lvl;
        held_lvl     = held_up ? up_lvl : dn_lvl;
        up_val       = sat_step(trig, STEP_VAL, 1'b1);
        dn_val       = sat_step(trig, STEP_VAL, 1'b0);
        first_val    = up_rise ? up_val : dn_val;
        held_val     = held_up ? up_val : dn_val;
    end

    // trig_changed is recomputed in every branch that may move trig, so a
    // clamped step leaves it equal to just the slope toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig         <= INIT_VAL;
            trig_slope   <= SLOPE_RISING;
            trig_changed <= 1'b0;
            state        <= ST_IDLE;
            rpt_cnt      <= '0;
            held_up      <= 1'b0;
        end else begin
            trig_changed <= slope_press;
            if (slope_press)
                trig_slope <= (trig_slope == SLOPE_RISING) ? SLOPE_FALLING : SLOPE_RISING;

            if (center_press) begin
                trig         <= INIT_VAL;
                trig_changed <= slope_press | (trig != INIT_VAL);
                state        <= ST_IDLE;
                rpt_cnt      <= '0;
            end else if (up_lvl && dn_lvl) begin
                state   <= ST_LOCK;
                rpt_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (up_rise ^ dn_rise) begin
                            trig         <= first_val;
                            trig_changed <= slope_press | (first_val != trig);
                            held_up      <= up_rise;
                            rpt_cnt      <= '0;
                            state        <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (!held_lvl) begin
                            state <= ST_IDLE;
                        end else if (rpt_cnt == DELAY_LAST) begin
                            trig         <= held_val;
                            trig_changed <= slope_press | (held_val != trig);
                            rpt_cnt      <= '0;
                            state        <= ST_REPEAT;
                        end else begin
                            rpt_cnt <= rpt_cnt + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (!held_lvl) begin
                            state <= ST_IDLE;
                        end else if (rpt_cnt == RATE_LAST) begin
                            trig         <= held_val;
                            trig_changed <= slope_press | (held_val != trig);
                            rpt_cnt      <= '0;
                        end else begin
                            rpt_cnt <= rpt_cnt + 1'b1;
                        end
                    end
                    ST_LOCK: begin
                        if (!up_lvl && !dn_lvl)
                            state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trig_level_ctrl.sv
// Directed and random checks of trig_level_ctrl against a window/age based reference model.
module tb_trig_level_ctrl;
    import trig_pkg::*;

    localparam int DB   = 4;
    localparam int DLY  = 20;
    localparam int RATE = 5;
    localparam int STP  = 4;
    localparam int INIT = 512;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_center = 1'b0;
    logic       btn_slope = 1'b0;
    logic [9:0] trig;
    logic       trig_slope;
    logic       trig_changed;

    always #5 clk = ~clk;

    trig_level_ctrl #(
        .DEBOUNCE_CYC(DB), .REPEAT_DELAY_CYC(DLY), .REPEAT_RATE_CYC(RATE),
        .STEP(STP), .LEVEL_INIT(INIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
        .btn_center(btn_center), .btn_slope(btn_slope),
        .trig(trig), .trig_slope(trig_slope), .trig_changed(trig_changed)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_pulse = 0;
    logic [9:0] obs_trig [0:1023];
    logic       obs_chg  [0:1023];

    // Reference model: raw history window per button, mode 0=idle 1=held 2=lock.
    int m_trig;
    bit m_slope, m_chg;
    bit pipe [4][6];
    bit m_lvl [4];
    bit m_rise [4];
    int m_mode, m_dir, m_age;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
    endfunction

    task automatic model_reset();
        m_trig = INIT; m_slope = 0; m_chg = 0;
        m_mode = 0; m_dir = 0; m_age = 0;
        for (int i = 0; i < 4; i++) begin
            m_lvl[i] = 0; m_rise[i] = 0;
            for (int j = 0; j < 6; j++) pipe[i][j] = 0;
        end
    endtask

    task automatic model_edge(input bit u, input bit d, input bit c, input bit s);
        int old_t;
        bit old_s;
        bit r [4];
        bit flip;
        old_t = m_trig;
        old_s = m_slope;
        if (m_rise[3]) m_slope = !m_slope;
        if (m_rise[2]) begin
            m_trig = INIT; m_mode = 0;
        end else if (m_lvl[0] && m_lvl[1]) begin
            m_mode = 2;
        end else if (m_mode == 0) begin
            if (m_rise[0] != m_rise[1]) begin
                m_dir = m_rise[0] ? 0 : 1;
                m_trig = sat(m_trig + ((m_dir == 0) ? STP : -STP));
                m_mode = 1; m_age = 0;
            end
        end else if (m_mode == 1) begin
            if (!m_lvl[m_dir]) m_mode = 0;
            else begin
                m_age++;
                if (m_age == DLY || (m_age > DLY && (m_age - DLY) % RATE == 0))
                    m_trig = sat(m_trig + ((m_dir == 0) ? STP : -STP));
            end
        end else if (!m_lvl[0] && !m_lvl[1]) begin
            m_mode = 0;
        end
        m_chg = (m_trig != old_t) || (m_slope != old_s);
        // Index j of pipe holds the raw value j edges ago; 2..5 are the synced samples.
        r[0] = u; r[1] = d; r[2] = c; r[3] = s;
        for (int i = 0; i < 4; i++) begin
            for (int j = 5; j > 0; j--) pipe[i][j] = pipe[i][j-1];
            pipe[i][0] = r[i];
            flip = 1;
            for (int j = 2; j < 2 + DB; j++) if (pipe[i][j] == m_lvl[i]) flip = 0;
            m_rise[i] = flip && !m_lvl[i];
            if (flip) m_lvl[i] = !m_lvl[i];
        end
    endtask

    // Starts and ends on a falling edge; inputs apply to the next rising edge.
    task automatic tick(input bit u, input bit d, input bit c, input bit s);
        btn_up = u; btn_down = d; btn_center = c; btn_slope = s;
        @(posedge clk);
        model_edge(u, d, c, s);
        cyc++;
        #1;
        if (cyc < 1024) begin
            obs_trig[cyc] = trig;
            obs_chg[cyc]  = trig_changed;
        end
        if (trig_changed === 1'b1) n_pulse++;
        chk("trig", 32'(trig), 32'(m_trig));
        chk("slope", 32'(trig_slope), 32'(m_slope));
        chk("changed", 32'(trig_changed), 32'(m_chg));
        @(negedge clk);
    endtask

    task automatic run(input bit u, input bit d, input bit c, input bit s, input int n);
        repeat (n) tick(u, d, c, s);
    endtask

    task automatic apply_reset(input bit u);
        @(negedge clk);
        rst_n = 1'b0;
        btn_up = u; btn_down = 0; btn_center = 0; btn_slope = 0;
        #1;
        chk("rst_trig", 32'(trig), 32'(INIT));
        chk("rst_slope", 32'(trig_slope), 32'(SLOPE_RISING));
        chk("rst_changed", 32'(trig_changed), 32'(0));
        chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic climb_to(input int target);
        int guard;
        guard = 0;
        while (m_trig < target - 20 && guard < 3000) begin
            tick(1, 0, 0, 0);
            guard++;
        end
        run(0, 0, 0, 0, 12);
        guard = 0;
        while (m_trig < target && guard < 50) begin
            run(1, 0, 0, 0, 8);
            run(0, 0, 0, 0, 8);
            guard++;
        end
        chk("climb_trig", 32'(trig), 32'(target));
    endtask

    initial begin
        bit ru, rd, rc, rs;
        model_reset();

        // Glitch shorter than the debounce window is ignored.
        apply_reset(0);
        n_pulse = 0;
        run(1, 0, 0, 0, 3);
        run(0, 0, 0, 0, 10);
        chk("glitch_trig", 32'(trig), 32'(512));
        chk("glitch_pulses", 32'(n_pulse), 32'(0));

        // Held from reset: first step, delay, then repeat rate.
        apply_reset(1);
        n_pulse = 0;
        run(1, 0, 0, 0, 40);
        chk("hold_c6", 32'(obs_trig[6]), 32'(512));
        chk("hold_c7", 32'(obs_trig[7]), 32'(516));
        chk("hold_p7", 32'(obs_chg[7]), 32'(1));
        chk("hold_c26", 32'(obs_trig[26]), 32'(516));
        chk("hold_c27", 32'(obs_trig[27]), 32'(520));
        chk("hold_c32", 32'(obs_trig[32]), 32'(524));
        chk("hold_c37", 32'(obs_trig[37]), 32'(528));
        chk("hold_pulses", 32'(n_pulse), 32'(4));
        run(0, 0, 0, 0, 10);

        // Saturation at the top of the range.
        climb_to(1020);
        n_pulse = 0;
        run(1, 0, 0, 0, 8); run(0, 0, 0, 0, 8);
        chk("sat_trig", 32'(trig), 32'(1023));
        chk("sat_pulses", 32'(n_pulse), 32'(1));
        n_pulse = 0;
        run(1, 0, 0, 0, 8); run(0, 0, 0, 0, 8);
        chk("sat2_trig", 32'(trig), 32'(1023));
        chk("sat2_pulses", 32'(n_pulse), 32'(0));

        // Both pressed locks out stepping until both released.
        apply_reset(0);
        run(1, 1, 0, 0, 10);
        chk("lock_trig", 32'(trig), 32'(512));
        chk("lock_state", 32'(dut.state), 32'(ST_LOCK));
        run(0, 1, 0, 0, 10);
        chk("lock_trig2", 32'(trig), 32'(512));
        chk("lock_state2", 32'(dut.state), 32'(ST_LOCK));
        run(0, 0, 0, 0, 10);
        chk("unlock_state", 32'(dut.state), 32'(ST_IDLE));
        run(1, 0, 0, 0, 8);
        chk("unlock_step", 32'(trig), 32'(516));
        run(0, 0, 0, 0, 8);

        // Slope toggling and centre restore.
        climb_to(600);
        n_pulse = 0;
        run(0, 0, 0, 1, 8); run(0, 0, 0, 0, 8);
        chk("slope1", 32'(trig_slope), 32'(SLOPE_FALLING));
        chk("slope1_pulses", 32'(n_pulse), 32'(1));
        run(0, 0, 0, 1, 8); run(0, 0, 0, 0, 8);
        chk("slope2", 32'(trig_slope), 32'(SLOPE_RISING));
        chk("slope2_pulses", 32'(n_pulse), 32'(2));
        run(0, 0, 1, 0, 8); run(0, 0, 0, 0, 8);
        chk("center_trig", 32'(trig), 32'(512));

        // Asynchronous reset in the middle of auto-repeat.
        apply_reset(0);
        run(1, 0, 0, 0, 30);
        chk("pre_rst_state", 32'(dut.state), 32'(ST_REPEAT));
        chk("pre_rst_trig", 32'(trig), 32'(520));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_trig", 32'(trig), 32'(512));
        chk("async_rst_changed", 32'(trig_changed), 32'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        run(1, 0, 0, 0, 10);
        chk("post_rst_c6", 32'(obs_trig[6]), 32'(512));
        chk("post_rst_c7", 32'(obs_trig[7]), 32'(516));
        run(0, 0, 0, 0, 10);

        // Random button activity against the model.
        ru = 0; rd = 0; rc = 0; rs = 0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 7) == 0) ru = !ru;
            if ($urandom_range(0, 7) == 0) rd = !rd;
            if ($urandom_range(0, 39) == 0) rc = !rc;
            if ($urandom_range(0, 11) == 0) rs = !rs;
            tick(ru, rd, rc, rs);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
